// File: rtl/adc_trig_capture.sv
// Single-channel ADC trigger capture: circular pre-trigger history in block RAM,
// rising-threshold trigger, post-trigger window, replay as one AXI-Stream packet.
// Optional macro CAP_FORCE_TRIG_EN adds the CapForceTrig input (software trigger).
module adc_trig_capture #(
  parameter int AdcChnls = 8,
  parameter int CapAddrW = 10
) (
  input  logic                AdcFrmClk,
  input  logic                SysRst_n,
  input  logic [7:0]          AdcDataValid,
  input  logic [15:0]         AdcDataCh0,
  input  logic [15:0]         AdcDataCh1,
  input  logic [15:0]         AdcDataCh2,
  input  logic [15:0]         AdcDataCh3,
  input  logic [15:0]         AdcDataCh4,
  input  logic [15:0]         AdcDataCh5,
  input  logic [15:0]         AdcDataCh6,
  input  logic [15:0]         AdcDataCh7,
  input  logic                CapArm,
  input  logic                CapAbort,
  input  logic [2:0]          CapChSel,
  input  logic [15:0]         CapThreshold,
  input  logic [CapAddrW-1:0] CapPreLen,
  input  logic [CapAddrW-1:0] CapPostLen,
`ifdef CAP_FORCE_TRIG_EN
  input  logic                CapForceTrig,
`endif
  output logic [15:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                CapBusy,
  output logic                CapTrigd,
  output logic                CapDone
);

  localparam int DEPTH = 1 << CapAddrW;
  typedef logic [CapAddrW-1:0] addr_t;
  typedef logic [CapAddrW:0]   len_t;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READ} state_t;

  state_t      r_st, w_nxt;
  logic [15:0] r_mem [DEPTH];
  logic [2:0]  r_chsel;
  logic [15:0] r_thr, r_prev, r_rdata, r_tdata;
  addr_t       r_pre, r_post, r_wp, r_cnt, r_pcnt, r_start, r_rp;
  len_t        r_rd_left;
  logic        r_pend, r_rd_last, r_tvalid, r_tlast, r_trigd, r_done;

  logic [15:0] w_ch [8];
  logic [15:0] w_smp;
  logic        w_sen, w_cross, w_force, w_wr, w_trig, w_rd, w_load, w_acc;
  addr_t       w_post_in, w_pre_in, w_start;
  len_t        w_sum;

  assign w_ch[0] = AdcDataCh0;
  assign w_ch[1] = AdcDataCh1;
  assign w_ch[2] = AdcDataCh2;
  assign w_ch[3] = AdcDataCh3;
  assign w_ch[4] = AdcDataCh4;
  assign w_ch[5] = AdcDataCh5;
  assign w_ch[6] = AdcDataCh6;
  assign w_ch[7] = AdcDataCh7;

  // Channels beyond AdcChnls never produce samples, so they can never trigger.
  assign w_sen   = (int'(r_chsel) < AdcChnls) && AdcDataValid[r_chsel];
  assign w_smp   = w_ch[r_chsel];
  assign w_cross = (r_prev < r_thr) && (w_smp >= r_thr);

  // Window sizing at arm: zero post means one sample; pre+post may not exceed the RAM.
  assign w_post_in = (CapPostLen == '0) ? addr_t'(1) : CapPostLen;
  assign w_sum     = {1'b0, CapPreLen} + {1'b0, w_post_in};
  assign w_pre_in  = (w_sum > len_t'(DEPTH)) ? addr_t'(len_t'(DEPTH) - {1'b0, w_post_in})
                                             : CapPreLen;

  assign w_acc   = r_tvalid && m_axis_tready;
  assign w_load  = r_pend && (!r_tvalid || m_axis_tready);
  assign w_rd    = (r_st == READ) && (r_rd_left != '0) && (!r_pend || w_load);
  assign w_start = w_trig ? (r_wp - r_pre) : r_start;

`ifdef CAP_FORCE_TRIG_EN
  logic r_fpend;
  assign w_force = CapForceTrig || r_fpend;
  always_ff @(posedge AdcFrmClk) begin
    if (!SysRst_n) r_fpend <= 1'b0;
    else           r_fpend <= (r_st == WAIT_TRIG) && !w_sen && w_force && !CapAbort;
  end
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_nxt  = r_st;
    w_wr   = 1'b0;
    w_trig = 1'b0;
    case (r_st)
      IDLE:      if (CapArm) w_nxt = PRE;
      PRE: begin
        if (r_pre == '0) w_nxt = WAIT_TRIG;
        else if (w_sen) begin
          w_wr = 1'b1;
          if (r_cnt == r_pre - addr_t'(1)) w_nxt = WAIT_TRIG;
        end
      end
      WAIT_TRIG: if (w_sen) begin
        w_wr = 1'b1;
        if (w_cross || w_force) begin
          w_trig = 1'b1;
          w_nxt  = (r_post == addr_t'(1)) ? READ : POST;
        end
      end
      POST: if (w_sen) begin
        w_wr = 1'b1;
        if (r_pcnt == r_post - addr_t'(1)) w_nxt = READ;
      end
      READ:      if (w_acc && r_tlast) w_nxt = IDLE;
      default:   w_nxt = IDLE;
    endcase
    if (CapAbort) begin
      w_nxt  = IDLE;
      w_wr   = 1'b0;
      w_trig = 1'b0;
    end
  end

  always_ff @(posedge AdcFrmClk) begin
    if (w_wr) r_mem[r_wp] <= w_smp;
    if (w_rd) r_rdata <= r_mem[r_rp];
  end

  always_ff @(posedge AdcFrmClk) begin
    if (!SysRst_n) begin
      r_st <= IDLE;
      r_chsel <= '0; r_thr <= '0; r_pre <= '0; r_post <= '0;
      r_wp <= '0; r_cnt <= '0; r_pcnt <= '0; r_start <= '0; r_rp <= '0;
      r_rd_left <= '0; r_prev <= '0; r_pend <= 1'b0; r_rd_last <= 1'b0;
      r_tdata <= '0; r_tvalid <= 1'b0; r_tlast <= 1'b0;
      r_trigd <= 1'b0; r_done <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_done <= 1'b0;
      if (r_st == IDLE && CapArm && !CapAbort) begin
        r_chsel <= CapChSel;
        r_thr   <= CapThreshold;
        r_pre   <= w_pre_in;
        r_post  <= w_post_in;
        r_wp    <= '0;
        r_cnt   <= '0;
        r_prev  <= '0;
      end
      if (w_wr) begin
        r_wp   <= r_wp + addr_t'(1);
        r_prev <= w_smp;
      end
      if (w_wr && r_st == PRE)  r_cnt  <= r_cnt + addr_t'(1);
      if (w_wr && r_st == POST) r_pcnt <= r_pcnt + addr_t'(1);
      if (w_trig) begin
        r_start <= r_wp - r_pre;
        r_pcnt  <= addr_t'(1);
        r_trigd <= 1'b1;
      end
      if (w_nxt == READ && r_st != READ) begin
        r_rp      <= w_start;
        r_rd_left <= {1'b0, r_pre} + {1'b0, r_post};
      end
      // r_rdata acts as the prefetch stage behind the output register.
      if (w_rd) begin
        r_rp      <= r_rp + addr_t'(1);
        r_rd_left <= r_rd_left - len_t'(1);
        r_rd_last <= (r_rd_left == len_t'(1));
        r_pend    <= 1'b1;
      end else if (w_load) begin
        r_pend <= 1'b0;
      end
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_rdata;
        r_tlast  <= r_rd_last;
      end else if (w_acc) begin
        r_tvalid <= 1'b0;
      end
      if (r_st == READ && w_acc && r_tlast) begin
        r_done   <= 1'b1;
        r_trigd  <= 1'b0;
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (CapAbort) begin
        r_done    <= 1'b0;
        r_trigd   <= 1'b0;
        r_tvalid  <= 1'b0;
        r_tlast   <= 1'b0;
        r_pend    <= 1'b0;
        r_rd_left <= '0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign CapBusy       = (r_st != IDLE);
  assign CapTrigd      = r_trigd;
  assign CapDone       = r_done;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture: ramp/constant source on channel 2,
// expected packet beats queued at arm time and compared as the stream drains.
module tb_adc_trig_capture;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        SysRst_n;
  logic [7:0]  AdcDataValid;
  logic [15:0] AdcDataCh0, AdcDataCh1, AdcDataCh2, AdcDataCh3;
  logic [15:0] AdcDataCh4, AdcDataCh5, AdcDataCh6, AdcDataCh7;
  logic        CapArm, CapAbort;
  logic [2:0]  CapChSel;
  logic [15:0] CapThreshold;
  logic [AW-1:0] CapPreLen, CapPostLen;
`ifdef CAP_FORCE_TRIG_EN
  logic        CapForceTrig;
`endif
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        CapBusy, CapTrigd, CapDone;

  always #5 clk = ~clk;

  adc_trig_capture #(.AdcChnls(8), .CapAddrW(AW)) dut (
    .AdcFrmClk(clk), .SysRst_n(SysRst_n), .AdcDataValid(AdcDataValid),
    .AdcDataCh0(AdcDataCh0), .AdcDataCh1(AdcDataCh1), .AdcDataCh2(AdcDataCh2),
    .AdcDataCh3(AdcDataCh3), .AdcDataCh4(AdcDataCh4), .AdcDataCh5(AdcDataCh5),
    .AdcDataCh6(AdcDataCh6), .AdcDataCh7(AdcDataCh7),
    .CapArm(CapArm), .CapAbort(CapAbort), .CapChSel(CapChSel),
    .CapThreshold(CapThreshold), .CapPreLen(CapPreLen), .CapPostLen(CapPostLen),
`ifdef CAP_FORCE_TRIG_EN
    .CapForceTrig(CapForceTrig),
`endif
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .CapBusy(CapBusy), .CapTrigd(CapTrigd), .CapDone(CapDone)
  );

  typedef struct packed { logic [15:0] d; logic l; } beat_t;
  beat_t sbq[$];

  int          n_chk = 0, n_pass = 0, n_fail = 0, beats_acc = 0;
  logic [15:0] ramp = '0, cval = '0;
  logic        src_const = 1'b0, vld = 1'b1, rdy_toggle = 1'b0, exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    AdcDataCh0 = 16'($urandom); AdcDataCh1 = 16'($urandom);
    AdcDataCh3 = 16'($urandom); AdcDataCh4 = 16'($urandom);
    AdcDataCh5 = 16'($urandom); AdcDataCh6 = 16'($urandom);
    AdcDataCh7 = 16'($urandom);
    AdcDataCh2 = !vld ? 16'($urandom) : (src_const ? cval : ramp);
    AdcDataValid = {5'h1F, vld, 2'b11};
  endtask

  // One clock: check outputs at negedge, then advance the source after the edge.
  task automatic cyc();
    beat_t e;
    @(negedge clk);
    chk("capdone", 32'(CapDone), 32'(exp_done));
    exp_done = 1'b0;
    if (m_axis_tvalid) begin
      if (sbq.size() == 0) chk("tvalid_unexpected", 32'(m_axis_tvalid), 32'd0);
      else if (m_axis_tready) begin
        e = sbq.pop_front();
        chk("tdata", 32'(m_axis_tdata), 32'(e.d));
        chk("tlast", 32'(m_axis_tlast), 32'(e.l));
        if (e.l) exp_done = 1'b1;
        beats_acc++;
      end else begin
        chk("tdata_hold", 32'(m_axis_tdata), 32'(sbq[0].d));
        chk("tlast_hold", 32'(m_axis_tlast), 32'(sbq[0].l));
      end
    end
    @(posedge clk);
    #1;
    if (vld && !src_const) ramp++;
    if (rdy_toggle) m_axis_tready = ~m_axis_tready;
    drive_src();
  endtask

  // Parameters go in for the arm cycle only; afterwards they are scrambled.
  task automatic arm(input logic [15:0] thr, input int pre, input int post);
    CapChSel = 3'd2; CapThreshold = thr;
    CapPreLen = AW'(pre); CapPostLen = AW'(post);
    CapArm = 1'b1;
    cyc();
    CapArm = 1'b0;
    CapChSel = 3'd5; CapThreshold = 16'd0;
    CapPreLen = AW'($urandom); CapPostLen = AW'($urandom);
    chk("busy_after_arm", 32'(CapBusy), 32'd1);
  endtask

  task automatic push_seq(input logic [15:0] first, input int n, input logic incr);
    for (int i = 0; i < n; i++)
      sbq.push_back('{d: incr ? first + 16'(i) : first, l: (i == n - 1)});
  endtask

  task automatic wait_pkt(input int budget);
    int k = 0;
    while ((sbq.size() != 0 || exp_done) && k < budget) begin
      cyc();
      k++;
    end
    if (k >= budget) chk("pkt_timeout", 32'(sbq.size()), 32'd0);
    chk("busy_idle", 32'(CapBusy), 32'd0);
    chk("trigd_idle", 32'(CapTrigd), 32'd0);
  endtask

  task automatic wait_trig(input int budget);
    int k = 0;
    while (!CapTrigd && k < budget) begin
      cyc();
      k++;
    end
    chk("trig_seen", 32'(CapTrigd), 32'd1);
  endtask

  initial begin
    int b0;
    SysRst_n = 1'b0; CapArm = 1'b0; CapAbort = 1'b0;
    CapChSel = 3'd0; CapThreshold = '0; CapPreLen = '0; CapPostLen = '0;
    m_axis_tready = 1'b1;
`ifdef CAP_FORCE_TRIG_EN
    CapForceTrig = 1'b0;
`endif
    drive_src();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_busy", 32'(CapBusy), 32'd0);
    chk("rst_trigd", 32'(CapTrigd), 32'd0);
    chk("rst_done", 32'(CapDone), 32'd0);
    @(posedge clk); #1;
    SysRst_n = 1'b1;
    cyc();

    // Arm together with abort stays idle.
    CapArm = 1'b1; CapAbort = 1'b1;
    cyc();
    CapArm = 1'b0; CapAbort = 1'b0;
    chk("arm_abort_idle", 32'(CapBusy), 32'd0);

    // Basic ramp capture.
    ramp = 16'd0; drive_src();
    arm(16'd100, 8, 8);
    push_seq(16'd92, 16, 1'b1);
    wait_pkt(400);

    // Backpressure: tready alternates every cycle.
    ramp = 16'd0; rdy_toggle = 1'b1; drive_src();
    arm(16'd100, 8, 8);
    push_seq(16'd92, 16, 1'b1);
    wait_pkt(600);
    rdy_toggle = 1'b0; m_axis_tready = 1'b1;

    // Constant above threshold must not trigger; rising ramp triggers at 50.
    src_const = 1'b1; cval = 16'd200; ramp = 16'd0; drive_src();
    arm(16'd50, 4, 4);
    repeat (20) cyc();
    chk("no_trig_const", 32'(CapTrigd), 32'd0);
    src_const = 1'b0; drive_src();
    push_seq(16'd46, 8, 1'b1);
    wait_pkt(300);

    // Pre length clamped to DEPTH-Post, window wraps the RAM.
    ramp = 16'd0; drive_src();
    arm(16'd1200, 1022, 8);
    push_seq(16'd184, 1024, 1'b1);
    wait_pkt(3000);

    // Valid gap during the post window.
    ramp = 16'd0; drive_src();
    arm(16'd100, 8, 8);
    push_seq(16'd92, 16, 1'b1);
    wait_trig(300);
    vld = 1'b0; drive_src();
    repeat (5) cyc();
    vld = 1'b1; drive_src();
    wait_pkt(300);

    // Abort mid-packet.
    ramp = 16'd0; drive_src();
    arm(16'd100, 8, 8);
    push_seq(16'd92, 16, 1'b1);
    b0 = beats_acc;
    for (int k = 0; k < 300 && beats_acc < b0 + 4; k++) cyc();
    chk("beats_before_abort", 32'(beats_acc - b0), 32'd4);
    CapAbort = 1'b1;
    cyc();
    CapAbort = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("abort_trigd", 32'(CapTrigd), 32'd0);
    chk("abort_busy", 32'(CapBusy), 32'd0);
    chk("abort_done", 32'(CapDone), 32'd0);
    @(posedge clk); #1;
    repeat (3) cyc();

    // Fresh arm after abort.
    ramp = 16'd300; drive_src();
    arm(16'd350, 8, 8);
    push_seq(16'd342, 16, 1'b1);
    wait_pkt(400);

    // Flat input far below threshold.
    src_const = 1'b1; cval = 16'd10; drive_src();
    arm(16'd1000, 4, 4);
    repeat (10) cyc();
    chk("flat_no_trig", 32'(CapTrigd), 32'd0);
`ifdef CAP_FORCE_TRIG_EN
    push_seq(16'd10, 8, 1'b0);
    CapForceTrig = 1'b1;
    cyc();
    CapForceTrig = 1'b0;
    wait_pkt(300);
`else
    repeat (20) cyc();
    chk("flat_no_trig_late", 32'(CapTrigd), 32'd0);
    chk("flat_still_busy", 32'(CapBusy), 32'd1);
    CapAbort = 1'b1;
    cyc();
    CapAbort = 1'b0;
    cyc();
    chk("flat_abort_idle", 32'(CapBusy), 32'd0);
`endif
    src_const = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
